// File: rtl/alu_md_if.sv
// Decode-slot bundle between the main control unit and the EX-stage ALU decoder.
// The master drives the instruction slot; the slave returns the decode, stall and HI/LO read data.
interface alu_md_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              stall;
    logic              out_valid;
    logic [3:0]        alu_control;
    logic              illegal;
    logic              hilo_sel;
    logic [DATA_W-1:0] hilo_rdata;
    logic              md_busy;

    modport master (
        output in_valid, alu_op, funct, rs_val, rt_val,
        input  stall, out_valid, alu_control, illegal, hilo_sel, hilo_rdata, md_busy
    );

    modport slave (
        input  in_valid, alu_op, funct, rs_val, rt_val,
        output stall, out_valid, alu_control, illegal, hilo_sel, hilo_rdata, md_busy
    );
endinterface

// File: rtl/alu_md_decoder.sv
// Registered EX-stage ALU-control decoder with an iterative mult/div sequencer and HI/LO registers.
// state | meaning:  IDLE | no op running  --  CALC | one mult/div bit per cycle  --  FIX | sign fix-up, HI/LO write
module alu_md_decoder #(
    parameter int DATA_W    = 32,
    parameter bit MD_ENABLE = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_md_if.slave  bus
);
    localparam logic [DATA_W-1:0] CNT_LOAD = DATA_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state, state_next;
    logic   md_busy, calc_step, fix_step;

    logic [3:0] dec_ctrl;
    logic       dec_illegal;
    logic       r_type, md_mul, md_div, md_sgn, md_mfhi, md_mthi, md_mflo, md_mtlo, md_op;
    logic       accept, start;

    logic [DATA_W:0]     work_hi;
    logic [DATA_W-1:0]   work_lo, opnd_b, cnt, hi_q, lo_q;
    logic                is_div, neg_q, neg_r, div_zero;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     mul_sum, div_shift, div_trial;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    always_comb begin
        dec_ctrl    = 4'b0000;
        dec_illegal = 1'b0;
        case (bus.alu_op)
            2'b00: dec_ctrl = 4'b0010;
            2'b01: dec_ctrl = 4'b0110;
            2'b11: dec_ctrl = 4'b0111;
            default: begin
                case (bus.funct)
                    6'b100000, 6'b100001: dec_ctrl = 4'b0010;
                    6'b100010, 6'b100011: dec_ctrl = 4'b0110;
                    6'b100100: dec_ctrl = 4'b0000;
                    6'b100101: dec_ctrl = 4'b0001;
                    6'b100110: dec_ctrl = 4'b0011;
                    6'b100111: dec_ctrl = 4'b0100;
                    6'b101010: dec_ctrl = 4'b0111;
                    6'b101011: dec_ctrl = 4'b1000;
                    6'b000000: dec_ctrl = 4'b1001;
                    6'b000010: dec_ctrl = 4'b1010;
                    6'b000011: dec_ctrl = 4'b1011;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011,
                    6'b010000, 6'b010001, 6'b010010, 6'b010011: dec_illegal = !MD_ENABLE;
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // The slt encoding (11) ignores funct, so only R-type slots can reach the sequencer.
    assign r_type  = (bus.alu_op == 2'b10);
    assign md_mul  = MD_ENABLE && r_type && (bus.funct[5:1] == 5'b01100);
    assign md_div  = MD_ENABLE && r_type && (bus.funct[5:1] == 5'b01101);
    assign md_sgn  = ~bus.funct[0];
    assign md_mfhi = MD_ENABLE && r_type && (bus.funct == 6'b010000);
    assign md_mthi = MD_ENABLE && r_type && (bus.funct == 6'b010001);
    assign md_mflo = MD_ENABLE && r_type && (bus.funct == 6'b010010);
    assign md_mtlo = MD_ENABLE && r_type && (bus.funct == 6'b010011);
    assign md_op   = md_mul | md_div | md_mfhi | md_mthi | md_mflo | md_mtlo;

    assign bus.stall   = bus.in_valid & md_busy & md_op;
    assign bus.md_busy = md_busy;
    assign accept      = bus.in_valid & ~bus.stall;
    assign start       = accept & (md_mul | md_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        md_busy   = (state != IDLE);
        calc_step = (state == CALC);
        fix_step  = (state == FIX);
    end

    assign mag_a = (md_sgn && bus.rs_val[DATA_W-1]) ? -bus.rs_val : bus.rs_val;
    assign mag_b = (md_sgn && bus.rt_val[DATA_W-1]) ? -bus.rt_val : bus.rt_val;

    // Multiply shifts the product right through work_hi:work_lo; divide shifts the dividend
    // out of work_lo into the remainder while quotient bits shift in behind it.
    assign mul_sum   = {1'b0, work_hi[DATA_W-1:0]} + (work_lo[0] ? {1'b0, opnd_b} : '0);
    assign div_shift = {work_hi[DATA_W-1:0], work_lo[DATA_W-1]};
    assign div_trial = div_shift - {1'b0, opnd_b};

    assign prod     = {work_hi[DATA_W-1:0], work_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = div_zero ? '1 : (neg_q ? -work_lo : work_lo);
    assign rem_fix  = neg_r ? -work_hi[DATA_W-1:0] : work_hi[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_hi  <= '0;
            work_lo  <= '0;
            opnd_b   <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (start) begin
            work_hi  <= '0;
            work_lo  <= mag_a;
            opnd_b   <= mag_b;
            cnt      <= CNT_LOAD;
            is_div   <= md_div;
            neg_q    <= md_sgn & (bus.rs_val[DATA_W-1] ^ bus.rt_val[DATA_W-1]);
            neg_r    <= md_sgn & bus.rs_val[DATA_W-1];
            div_zero <= (bus.rt_val == '0);
        end else if (calc_step) begin
            cnt <= cnt - 1'b1;
            if (!is_div) begin
                work_hi <= {1'b0, mul_sum[DATA_W:1]};
                work_lo <= {mul_sum[0], work_lo[DATA_W-1:1]};
            end else if (!div_trial[DATA_W]) begin
                work_hi <= div_trial;
                work_lo <= {work_lo[DATA_W-2:0], 1'b1};
            end else begin
                work_hi <= div_shift;
                work_lo <= {work_lo[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Stall keeps every HI/LO instruction out while busy, so mthi/mtlo never races the FIX write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (fix_step) begin
            hi_q <= is_div ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
            lo_q <= is_div ? quo_fix : prod_fix[DATA_W-1:0];
        end else if (accept) begin
            if (md_mthi) hi_q <= bus.rs_val;
            if (md_mtlo) lo_q <= bus.rs_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid   <= 1'b0;
            bus.alu_control <= 4'b0000;
            bus.illegal     <= 1'b0;
            bus.hilo_sel    <= 1'b0;
            bus.hilo_rdata  <= '0;
        end else begin
            bus.out_valid <= accept;
            if (accept) begin
                bus.alu_control <= dec_ctrl;
                bus.illegal     <= dec_illegal;
                bus.hilo_sel    <= md_mfhi | md_mflo;
                bus.hilo_rdata  <= md_mfhi ? hi_q : (md_mflo ? lo_q : '0);
            end
        end
    end
endmodule
